// File: rtl/mem_stage_pkg.sv
// Shared pipeline definitions for the MEM stage: access FSM encoding, control bundle
// and the default memory latency.
package mem_stage_pkg;

   localparam int MEM_LATENCY_DEF = 2;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } state_e;

   typedef struct packed {
      logic branch;
      logic mem_read;
      logic mem_write;
      logic mem_to_reg;
      logic reg_write;
   } ctrl_t;

endpackage

// File: rtl/mem_stage_if.sv
// Execute-to-MEM inputs and MEM/WB outputs of the memory stage.
// master drives the execute side, slave is the stage itself.
interface mem_stage_if #(
   parameter int PC_SIZE = 10
);
   logic [PC_SIZE-1:0] PC_jump;
   logic               zero;
   logic [7:0]         ALU_result;
   logic [7:0]         write_data;
   logic [4:0]         rd_in;
   logic               valid_in;
   logic               branch_in;
   logic               mem_read_in;
   logic               mem_write_in;
   logic               mem_to_reg_in;
   logic               reg_write_in;
   logic               flush;

   logic               stall;
   logic               pc_src;
   logic [PC_SIZE-1:0] PC_branch;
   logic               wb_valid;
   logic               wb_mem_to_reg;
   logic               wb_reg_write;
   logic [4:0]         wb_rd;
   logic [7:0]         wb_read_data;
   logic [7:0]         wb_alu_result;

   modport master (
      output PC_jump, zero, ALU_result, write_data, rd_in, valid_in, branch_in,
             mem_read_in, mem_write_in, mem_to_reg_in, reg_write_in, flush,
      input  stall, pc_src, PC_branch, wb_valid, wb_mem_to_reg, wb_reg_write,
             wb_rd, wb_read_data, wb_alu_result
   );

   modport slave (
      input  PC_jump, zero, ALU_result, write_data, rd_in, valid_in, branch_in,
             mem_read_in, mem_write_in, mem_to_reg_in, reg_write_in, flush,
      output stall, pc_src, PC_branch, wb_valid, wb_mem_to_reg, wb_reg_write,
             wb_rd, wb_read_data, wb_alu_result
   );
endinterface

// File: rtl/mem_stage_data_memory.sv
// Byte-wide data memory: synchronous write, asynchronous read, contents never reset.
module data_memory #(
   parameter int DEPTH = 256
) (
   input  logic       clk,
   input  logic       we,
   input  logic [7:0] addr,
   input  logic [7:0] wdata,
   output logic [7:0] rdata
);
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [7:0]    mem_q [DEPTH];
   logic [AW-1:0] idx;

   assign idx = AW'(addr);

   always_ff @(posedge clk) begin
      if (we) begin
         mem_q[idx] <= wdata;
      end
   end

   assign rdata = mem_q[idx];
endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: stage register S, multi-cycle data-memory access FSM and MEM/WB register.
// state   | meaning
// ST_IDLE | no access in progress; a mem op in S either commits now (latency 1) or starts BUSY
// ST_BUSY | access in progress, cnt counts occupied cycles; commits when cnt reaches latency-1
module mem_stage
   import mem_stage_pkg::*;
#(
   parameter int PC_SIZE     = 10,
   parameter int MEM_LATENCY = MEM_LATENCY_DEF,
   parameter int DMEM_DEPTH  = 256
) (
   input logic        clk,
   input logic        reset,
   mem_stage_if.slave bus
);
   localparam logic [2:0] LAST_CNT = 3'(MEM_LATENCY - 1);

   state_e             state_q, state_d;
   logic [2:0]         cnt_q, cnt_d;

   logic               s_valid_q;
   ctrl_t              s_ctrl_q;
   logic [PC_SIZE-1:0] s_pc_q;
   logic               s_zero_q;
   logic [7:0]         s_alu_q;
   logic [7:0]         s_wdata_q;
   logic [4:0]         s_rd_q;

   logic               wb_valid_q, wb_mem_to_reg_q, wb_reg_write_q;
   logic [4:0]         wb_rd_q;
   logic [7:0]         wb_read_data_q, wb_alu_result_q;

   logic               mem_op, stall, abort, mem_we;
   logic [7:0]         mem_rdata;

   assign mem_op = s_valid_q & (s_ctrl_q.mem_read | s_ctrl_q.mem_write);

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         ST_IDLE: begin
            if (mem_op && (MEM_LATENCY > 1) && !bus.flush) begin
               state_d = ST_BUSY;
               cnt_d   = 3'd1;
            end
         end
         ST_BUSY: begin
            if (bus.flush || (cnt_q == LAST_CNT)) begin
               state_d = ST_IDLE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 3'd1;
            end
         end
      endcase
   end

   // A flush while BUSY kills the access even on its final cycle.
   always_comb begin
      stall = 1'b0;
      abort = 1'b0;
      case (state_q)
         ST_IDLE: stall = mem_op && (MEM_LATENCY > 1);
         ST_BUSY: begin
            stall = (cnt_q != LAST_CNT);
            abort = bus.flush;
         end
      endcase
   end

   assign mem_we = mem_op & s_ctrl_q.mem_write & ~stall & ~abort & ~reset;

   data_memory #(.DEPTH(DMEM_DEPTH)) u_dmem (
      .clk   (clk),
      .we    (mem_we),
      .addr  (s_alu_q),
      .wdata (s_wdata_q),
      .rdata (mem_rdata)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         s_valid_q <= 1'b0;
         s_ctrl_q  <= '0;
         s_pc_q    <= '0;
         s_zero_q  <= 1'b0;
         s_alu_q   <= '0;
         s_wdata_q <= '0;
         s_rd_q    <= '0;
      end else if (!stall) begin
         s_valid_q <= bus.valid_in & ~bus.flush;
         s_ctrl_q  <= '{branch:     bus.branch_in,
                        mem_read:   bus.mem_read_in,
                        mem_write:  bus.mem_write_in,
                        mem_to_reg: bus.mem_to_reg_in,
                        reg_write:  bus.reg_write_in};
         s_pc_q    <= bus.PC_jump;
         s_zero_q  <= bus.zero;
         s_alu_q   <= bus.ALU_result;
         s_wdata_q <= bus.write_data;
         s_rd_q    <= bus.rd_in;
      end else if (bus.flush) begin
         s_valid_q <= 1'b0;
      end
   end

   // Read data is sampled before the same-edge write lands, so load+store returns old contents.
   always_ff @(posedge clk) begin
      if (reset) begin
         wb_valid_q      <= 1'b0;
         wb_mem_to_reg_q <= 1'b0;
         wb_reg_write_q  <= 1'b0;
         wb_rd_q         <= '0;
         wb_read_data_q  <= '0;
         wb_alu_result_q <= '0;
      end else if (!stall) begin
         wb_valid_q      <= s_valid_q & ~abort;
         wb_reg_write_q  <= s_valid_q & ~abort & s_ctrl_q.reg_write;
         wb_mem_to_reg_q <= s_ctrl_q.mem_to_reg;
         wb_rd_q         <= s_rd_q;
         wb_alu_result_q <= s_alu_q;
         if (mem_op && s_ctrl_q.mem_read && !abort) begin
            wb_read_data_q <= mem_rdata;
         end
      end
   end

   assign bus.stall         = stall;
   assign bus.pc_src        = s_valid_q & s_ctrl_q.branch & s_zero_q;
   assign bus.PC_branch     = s_pc_q;
   assign bus.wb_valid      = wb_valid_q;
   assign bus.wb_mem_to_reg = wb_mem_to_reg_q;
   assign bus.wb_reg_write  = wb_reg_write_q;
   assign bus.wb_rd         = wb_rd_q;
   assign bus.wb_read_data  = wb_read_data_q;
   assign bus.wb_alu_result = wb_alu_result_q;
endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: scoreboarded instruction stream on a latency-2 stage,
// plus directed reset-during-access checks on a latency-4 stage.
module tb_mem_stage;
   import mem_stage_pkg::*;

   localparam int PCW = 10;

   typedef struct packed {
      logic [PCW-1:0] pc;
      logic           zero;
      logic [7:0]     alu;
      logic [7:0]     wdata;
      logic [4:0]     rd;
      logic           br, mr, mw, m2r, rw, fl;
   } ins_t;

   typedef struct {
      logic [4:0] rd;
      logic [7:0] alu;
      logic [7:0] rdata;
      logic       is_load;
      logic       m2r;
      logic       rw;
   } sb_t;

   logic clk = 1'b0;
   logic reset, reset4;
   always #5 clk = ~clk;

   mem_stage_if #(.PC_SIZE(PCW)) bus  ();
   mem_stage_if #(.PC_SIZE(PCW)) bus4 ();

   mem_stage #(.PC_SIZE(PCW), .MEM_LATENCY(2), .DMEM_DEPTH(256)) u_dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   mem_stage #(.PC_SIZE(PCW), .MEM_LATENCY(4), .DMEM_DEPTH(256)) u_dut4 (
      .clk   (clk),
      .reset (reset4),
      .bus   (bus4.slave)
   );

   int   n_checks = 0;
   int   n_errors = 0;
   sb_t  sb_q[$];
   logic [7:0] model_mem [256];
   logic stall_prev = 1'b1;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic ins_t mk_alu(input logic [4:0] rd, input logic [7:0] res);
      ins_t i = '0;
      i.rd = rd; i.alu = res; i.rw = 1'b1;
      return i;
   endfunction

   function automatic ins_t mk_store(input logic [7:0] addr, input logic [7:0] data);
      ins_t i = '0;
      i.alu = addr; i.wdata = data; i.mw = 1'b1;
      return i;
   endfunction

   function automatic ins_t mk_load(input logic [4:0] rd, input logic [7:0] addr);
      ins_t i = '0;
      i.rd = rd; i.alu = addr; i.mr = 1'b1; i.m2r = 1'b1; i.rw = 1'b1;
      return i;
   endfunction

   function automatic ins_t mk_branch(input logic [PCW-1:0] pc, input logic z);
      ins_t i = '0;
      i.pc = pc; i.zero = z; i.br = 1'b1;
      return i;
   endfunction

   // Called at a negedge where the stage accepts; returns at the last negedge the op sits in S.
   task automatic send(input ins_t ins, input int exp_stalls, input string tag, input bit retire);
      sb_t e;
      int  n;
      bus.PC_jump = ins.pc;      bus.zero = ins.zero;
      bus.ALU_result = ins.alu;  bus.write_data = ins.wdata;
      bus.rd_in = ins.rd;        bus.branch_in = ins.br;
      bus.mem_read_in = ins.mr;  bus.mem_write_in = ins.mw;
      bus.mem_to_reg_in = ins.m2r; bus.reg_write_in = ins.rw;
      bus.flush = ins.fl;        bus.valid_in = 1'b1;
      if (retire) begin
         e.rd = ins.rd; e.alu = ins.alu; e.is_load = ins.mr;
         e.rdata = model_mem[ins.alu]; e.m2r = ins.m2r; e.rw = ins.rw;
         if (ins.mw) model_mem[ins.alu] = ins.wdata;
         sb_q.push_back(e);
      end
      @(posedge clk); #1;
      bus.valid_in = 1'b0;
      bus.flush    = 1'b0;
      n = 0;
      @(negedge clk);
      while (bus.stall && n < 20) begin
         n++;
         @(negedge clk);
      end
      check_eq({tag, "_stalls"}, 64'(n), 64'(exp_stalls));
   endtask

   task automatic op4(input logic mr, input logic mw, input logic [7:0] addr, input logic [7:0] wd);
      bus4.valid_in = 1'b1; bus4.mem_read_in = mr; bus4.mem_write_in = mw;
      bus4.ALU_result = addr; bus4.write_data = wd; bus4.rd_in = 5'd2;
      bus4.reg_write_in = mr; bus4.mem_to_reg_in = mr;
      @(posedge clk); #1;
      bus4.valid_in = 1'b0; bus4.mem_read_in = 1'b0; bus4.mem_write_in = 1'b0;
   endtask

   task automatic count4(output int n);
      n = 0;
      @(negedge clk);
      while (bus4.stall && n < 20) begin
         n++;
         @(negedge clk);
      end
   endtask

   // A MEM/WB update happens on an edge whose preceding cycle had stall low.
   always @(negedge clk) begin : monitor
      sb_t e;
      if (!stall_prev && bus.wb_valid === 1'b1) begin
         check_eq("sb_avail", 64'(sb_q.size() != 0), 64'd1);
         if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            check_eq("wb_fields",
                     64'({bus.wb_rd, bus.wb_alu_result, bus.wb_mem_to_reg, bus.wb_reg_write}),
                     64'({e.rd, e.alu, e.m2r, e.rw}));
            if (e.is_load) check_eq("wb_read_data", 64'(bus.wb_read_data), 64'(e.rdata));
         end
      end
      stall_prev = bus.stall | reset;
   end

   initial begin : watchdog
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "timeout");
   end

   initial begin : stim
      int n;
      reset = 1'b1; reset4 = 1'b1;
      bus.PC_jump = '0; bus.zero = 1'b0; bus.ALU_result = '0; bus.write_data = '0;
      bus.rd_in = '0; bus.valid_in = 1'b0; bus.branch_in = 1'b0; bus.mem_read_in = 1'b0;
      bus.mem_write_in = 1'b0; bus.mem_to_reg_in = 1'b0; bus.reg_write_in = 1'b0; bus.flush = 1'b0;
      bus4.PC_jump = '0; bus4.zero = 1'b0; bus4.ALU_result = '0; bus4.write_data = '0;
      bus4.rd_in = '0; bus4.valid_in = 1'b0; bus4.branch_in = 1'b0; bus4.mem_read_in = 1'b0;
      bus4.mem_write_in = 1'b0; bus4.mem_to_reg_in = 1'b0; bus4.reg_write_in = 1'b0; bus4.flush = 1'b0;

      repeat (3) @(posedge clk);
      #1;
      check_eq("rst_outs",
               64'({bus.stall, bus.pc_src, bus.wb_valid, bus.wb_mem_to_reg, bus.wb_reg_write,
                    bus.wb_rd, bus.wb_alu_result, bus.wb_read_data, bus.PC_branch}), 64'd0);
      reset = 1'b0;
      @(negedge clk);

      send(mk_store(8'h10, 8'hA5), 1, "st10", 1);
      send(mk_load(5'd4, 8'h10), 1, "ld10", 1);
      send(mk_alu(5'd3, 8'h7F), 0, "alu3", 1);

      send(mk_branch(10'h2C4, 1'b1), 0, "br_t", 1);
      check_eq("br_t_pc_src", 64'(bus.pc_src), 64'd1);
      check_eq("br_t_pc_branch", 64'(bus.PC_branch), 64'h2C4);
      send(mk_branch(10'h155, 1'b0), 0, "br_nt", 1);
      check_eq("br_nt_pc_src", 64'(bus.pc_src), 64'd0);
      check_eq("br_nt_pc_branch", 64'(bus.PC_branch), 64'h155);

      // Flush during BUSY of a store: no write, bubble in MEM/WB.
      send(mk_store(8'h20, 8'h3C), 1, "st20a", 1);
      send(mk_store(8'h20, 8'hEE), 1, "st20b", 0);
      bus.flush = 1'b1;
      @(posedge clk); #1;
      bus.flush = 1'b0;
      check_eq("fl_busy_wb_valid", 64'(bus.wb_valid), 64'd0);
      check_eq("fl_busy_stall", 64'(bus.stall), 64'd0);
      send(mk_load(5'd6, 8'h20), 1, "ld20", 1);

      // Flush with stall low: older op retires, newly captured op is bubbled.
      send(mk_alu(5'd9, 8'h31), 0, "aluA", 1);
      begin
         ins_t b;
         b = mk_alu(5'd10, 8'h42);
         b.fl = 1'b1;
         send(b, 0, "aluB_fl", 0);
      end
      @(posedge clk); #1;
      check_eq("fl_bubble_wb_valid", 64'(bus.wb_valid), 64'd0);
      check_eq("fl_bubble_reg_write", 64'(bus.wb_reg_write), 64'd0);
      @(negedge clk);

      // Load and store together return pre-write contents.
      send(mk_store(8'h05, 8'h11), 1, "st05", 1);
      begin
         ins_t ls;
         ls = mk_load(5'd7, 8'h05);
         ls.mw = 1'b1;
         ls.wdata = 8'h22;
         send(ls, 1, "ldst05", 1);
      end
      send(mk_load(5'd8, 8'h05), 1, "ld05", 1);
      repeat (4) @(negedge clk);
      check_eq("sb_drained", 64'(sb_q.size()), 64'd0);

      // Latency-4 stage: reset mid-load and on a store's commit edge.
      reset4 = 1'b0;
      @(negedge clk);
      op4(1'b0, 1'b1, 8'h30, 8'h99);
      count4(n);
      check_eq("ml4_st_stalls", 64'(n), 64'd3);
      op4(1'b1, 1'b0, 8'h30, 8'h00);
      check_eq("ml4_st_wb_valid", 64'(bus4.wb_valid), 64'd1);
      @(posedge clk); #1;
      check_eq("ml4_mid_stall", 64'(bus4.stall), 64'd1);
      reset4 = 1'b1;
      @(posedge clk); #1;
      reset4 = 1'b0;
      check_eq("ml4_rst_outs",
               64'({bus4.stall, bus4.pc_src, bus4.wb_valid, bus4.wb_mem_to_reg, bus4.wb_reg_write,
                    bus4.wb_rd, bus4.wb_alu_result, bus4.wb_read_data, bus4.PC_branch}), 64'd0);
      op4(1'b0, 1'b1, 8'h30, 8'h66);
      count4(n);
      check_eq("ml4_post_rst_stalls", 64'(n), 64'd3);
      reset4 = 1'b1;
      @(posedge clk); #1;
      reset4 = 1'b0;
      op4(1'b1, 1'b0, 8'h30, 8'h00);
      count4(n);
      check_eq("ml4_ld_stalls", 64'(n), 64'd3);
      @(posedge clk); #1;
      check_eq("ml4_ld_wb_valid", 64'(bus4.wb_valid), 64'd1);
      check_eq("ml4_ld_data", 64'(bus4.wb_read_data), 64'h99);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end
endmodule
